// File: rtl/processor_pkg.sv
// Shared processor definitions: the fetch FSM state type, the branch opcode
// and the ARM-style condition-code encodings.
package processor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [3:0] OP_BRANCH = 4'b1010;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'ha;
  localparam logic [3:0] CC_LT = 4'hb;
  localparam logic [3:0] CC_GT = 4'hc;
  localparam logic [3:0] CC_LE = 4'hd;
  localparam logic [3:0] CC_AL = 4'he;
  localparam logic [3:0] CC_NV = 4'hf;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and RAM (slave).
//   fetch_req  : read request, held until acknowledged
//   pcinstruct : fetch address (zero-extended PC)
//   fetch_ack  : mem_rdata is valid this cycle
//   mem_rdata  : instruction word
interface fetch_unit_if;
  logic        fetch_req;
  logic [31:0] pcinstruct;
  logic        fetch_ack;
  logic [31:0] mem_rdata;

  modport master (output fetch_req, pcinstruct, input  fetch_ack, mem_rdata);
  modport slave  (input  fetch_req, pcinstruct, output fetch_ack, mem_rdata);
endinterface

// File: rtl/cond_eval.sv
// ARM condition-code evaluator.
//   cond  : condition field of the instruction
//   flags : {N,Z,C,V}
//   pass  : condition holds (AL always, NV never)
module cond_eval
  import processor_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = f_z;
      CC_NE:   pass = !f_z;
      CC_CS:   pass = f_c;
      CC_CC:   pass = !f_c;
      CC_MI:   pass = f_n;
      CC_PL:   pass = !f_n;
      CC_VS:   pass = f_v;
      CC_VC:   pass = !f_v;
      CC_HI:   pass = f_c && !f_z;
      CC_LS:   pass = !f_c || f_z;
      CC_GE:   pass = (f_n == f_v);
      CC_LT:   pass = (f_n != f_v);
      CC_GT:   pass = !f_z && (f_n == f_v);
      CC_LE:   pass = f_z || (f_n != f_v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests instruction words from RAM, presents each
// one to issue, evaluates its condition against the latched flags and
// advances or redirects the PC.
//   clk, reset       : clock, asynchronous active-low reset
//   enable           : run enable
//   stall            : memory controller busy, freezes issue
//   mem              : instruction bus (fetch_req/pcinstruct/fetch_ack/mem_rdata)
//   n, z, c, v       : ALU flags, captured when flag_we on a passing issue
//   fetch            : registered instruction word
//   instr_valid      : instruction valid for issue this cycle
//   exec_ok          : condition passed
//   flags            : latched {N,Z,C,V}
// Build option: define COND_EXEC_EN to enable conditional execution; without
// it exec_ok is tied high and every branch is taken.
//
// state | meaning
// IDLE  | not running, no request outstanding
// REQ   | fetch_req high, waiting for fetch_ack
// ISSUE | fetch holds a valid instruction, instr_valid high
// HOLD  | issue frozen by stall, waiting to re-issue the same word
module fetch_unit
  import processor_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                stall,
  fetch_unit_if.master        mem,
  input  logic                n,
  input  logic                z,
  input  logic                c,
  input  logic                v,
  input  logic                flag_we,
  output logic [31:0]         fetch,
  output logic                instr_valid,
  output logic                exec_ok,
  output logic [3:0]          flags
);
  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       fetch_q;
  logic [3:0]        flags_q;
  logic              fetch_req_q;
  logic              instr_valid_q;
  logic              take_branch;
  logic [31:0]       pc_ext;

`ifdef COND_EXEC_EN
  cond_eval u_cond (
    .cond  (fetch_q[31:28]),
    .flags (flags_q),
    .pass  (exec_ok)
  );
`else
  assign exec_ok = 1'b1;
`endif

  // The low ADDR_W bits of the word are the signed offset; adding them modulo
  // 2^ADDR_W is the same as adding the sign-extended value.
  assign take_branch = (fetch_q[27:24] == OP_BRANCH) && exec_ok;
  assign pc_d = take_branch ? pc_q + ADDR_W'(1) + fetch_q[ADDR_W-1:0]
                            : pc_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_q       <= '0;
      flags_q       <= '0;
      fetch_req_q   <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      if (flag_we && instr_valid_q && exec_ok) flags_q <= {n, z, c, v};
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q     <= REQ;
            fetch_req_q <= 1'b1;
          end
        end
        // An outstanding request always completes, even if enable drops.
        REQ: begin
          if (mem.fetch_ack) begin
            fetch_q       <= mem.mem_rdata;
            state_q       <= ISSUE;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          instr_valid_q <= 1'b0;
          if (stall) begin
            state_q <= HOLD;
          end else begin
            pc_q <= pc_d;
            if (enable) begin
              state_q     <= REQ;
              fetch_req_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_q       <= ISSUE;
            instr_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          fetch_req_q   <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pc_ext             = '0;
    pc_ext[ADDR_W-1:0] = pc_q;
  end

  assign mem.fetch_req  = fetch_req_q;
  assign mem.pcinstruct = pc_ext;
  assign fetch          = fetch_q;
  assign instr_valid    = instr_valid_q;
  assign flags          = flags_q;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef COND_EXEC_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable, stall, n, z, c, v, flag_we;
  logic [31:0] fetch;
  logic        instr_valid, exec_ok;
  logic [3:0]  flags;

  fetch_unit_if bus ();

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'd0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .mem(bus),
    .n(n), .z(z), .c(c), .v(v), .flag_we(flag_we),
    .fetch(fetch), .instr_valid(instr_valid), .exec_ok(exec_ok), .flags(flags)
  );

  logic [3:0] ce_cond, ce_flags;
  logic       ce_pass;
  cond_eval u_ce (.cond(ce_cond), .flags(ce_flags), .pass(ce_pass));

  int          total = 0;
  int          bad = 0;
  int          iv_cnt = 0;
  bit          chk_en = 0;
  bit          ack_hold = 0;
  logic [31:0] mem [256];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_cond(input logic [3:0] cc, input logic [3:0] f);
    bit nf, zf, cf, vf;
    {nf, zf, cf, vf} = f;
    case (cc)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return nf;
      4'd5:  return !nf;
      4'd6:  return vf;
      4'd7:  return !vf;
      4'd8:  return cf && !zf;
      4'd9:  return !cf || zf;
      4'd10: return nf == vf;
      4'd11: return nf != vf;
      4'd12: return !zf && (nf == vf);
      4'd13: return zf || (nf != vf);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_exec(input logic [3:0] cc, input logic [3:0] f);
    return COND ? m_cond(cc, f) : 1'b1;
  endfunction

  typedef enum int {P_IDLE, P_REQ, P_ISSUE, P_HOLD} phase_e;
  phase_e      ph;
  int          m_pc;
  logic [31:0] m_word;
  logic [3:0]  m_flags;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = P_IDLE; m_pc = 0; m_word = '0; m_flags = '0;
    end else begin
      case (ph)
        P_IDLE: if (enable) ph = P_REQ;
        P_REQ: if (bus.fetch_ack) begin m_word = bus.mem_rdata; ph = P_ISSUE; end
        P_ISSUE: begin
          bit ok;
          int step;
          ok = m_exec(m_word[31:28], m_flags);
          if (flag_we && ok) m_flags = {n, z, c, v};
          if (stall) ph = P_HOLD;
          else begin
            step = 1;
            if (m_word[27:24] == 4'hA && ok) step = 1 + int'($signed(m_word[7:0]));
            m_pc = (m_pc + step + 256) % 256;
            ph = enable ? P_REQ : P_IDLE;
          end
        end
        default: if (!stall) ph = P_ISSUE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("m_fetch_req", 32'(bus.fetch_req), 32'(ph == P_REQ));
      check("m_instr_valid", 32'(instr_valid), 32'(ph == P_ISSUE));
      check("m_pcinstruct", bus.pcinstruct, 32'(m_pc));
      check("m_fetch", fetch, m_word);
      check("m_flags", 32'(flags), 32'(m_flags));
      check("m_exec_ok", 32'(exec_ok), 32'(m_exec(m_word[31:28], m_flags)));
      if (instr_valid) iv_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      bus.fetch_ack = bus.fetch_req && !ack_hold;
      bus.mem_rdata = mem[bus.pcinstruct[7:0]];
    end
  endtask

  task automatic next_fetch(output logic [31:0] a);
    bit seen_low;
    bit got;
    seen_low = !bus.fetch_req;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      cyc(1);
      if (!bus.fetch_req) seen_low = 1;
      else if (seen_low) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL next_fetch_timeout: no new request within 40 cycles at %0t", $time);
      a = '1;
    end else begin
      a = bus.pcinstruct;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hE000_0000 | 32'(i);
  endtask

  task automatic do_reset();
    reset = 0;
    cyc(2);
    reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          ivs;
    reset = 0; enable = 0; stall = 0; {n, z, c, v} = 4'b0; flag_we = 0;
    bus.fetch_ack = 0; bus.mem_rdata = '0;
    fill_mem();

    for (int i = 0; i < 256; i++) begin
      ce_cond = 4'(i >> 4);
      ce_flags = 4'(i);
      #1;
      check("cond_eval", 32'(ce_pass), 32'(m_cond(ce_cond, ce_flags)));
    end
    check("cond_eq_z1", 32'(m_cond(4'h0, 4'b0100)), 32'd1);
    check("cond_gt_nv", 32'(m_cond(4'hC, 4'b1001)), 32'd1);

    // sequential fetch and AL branch
    mem[5] = 32'hEA0000FE;
    chk_en = 1;
    do_reset();
    check("rst_pc", bus.pcinstruct, 32'd0);
    check("rst_req", 32'(bus.fetch_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fetch", fetch, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_exec_ok", 32'(exec_ok), COND ? 32'd0 : 32'd1);
    iv_cnt = 0;
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      next_fetch(a);
      check("seq_pc", a, 32'(i));
    end
    check("iv_pulses", 32'(iv_cnt), 32'd3);
    next_fetch(a); check("seq_pc4", a, 32'd4);
    next_fetch(a); check("seq_pc5", a, 32'd5);
    cyc(1);
    check("br_word", fetch, 32'hEA0000FE);
    check("br_valid", 32'(instr_valid), 32'd1);
    next_fetch(a); check("br_target", a, 32'd4);
    mem[5] = 32'hE000_0005;
    next_fetch(a); check("after_br5", a, 32'd5);
    next_fetch(a); check("after_br6", a, 32'd6);

    // BEQ not taken, flag_we ignored while idle
    enable = 0;
    fill_mem();
    mem[2] = 32'h0A000003;
    do_reset();
    flag_we = 1; {n, z, c, v} = 4'b1111;
    cyc(2);
    check("idle_flag_we", 32'(flags), 32'd0);
    flag_we = 0; {n, z, c, v} = 4'b0000;
    enable = 1;
    next_fetch(a); next_fetch(a); next_fetch(a);
    check("beq_pc", a, 32'd2);
    cyc(1);
    check("beq_word", fetch, 32'h0A000003);
    check("beq_ok_z0", 32'(exec_ok), COND ? 32'd0 : 32'd1);
    next_fetch(a);
    check("beq_next_z0", a, COND ? 32'd3 : 32'd6);

    // BEQ taken, stall, stalled branch, wrap, enable drop, async reset
    enable = 0;
    fill_mem();
    mem[2] = 32'h0A000003;
    mem[8] = 32'hEA000005;
    mem[14] = 32'hEA0000F0;
    do_reset();
    flag_we = 1; {n, z, c, v} = 4'b0100;
    enable = 1;
    next_fetch(a); check("t3_pc0", a, 32'd0);
    next_fetch(a); check("t3_pc1", a, 32'd1);
    check("flags_cap", 32'(flags), 32'b0100);
    flag_we = 0; {n, z, c, v} = 4'b0000;
    next_fetch(a); check("t3_pc2", a, 32'd2);
    cyc(1);
    check("beq_ok_z1", 32'(exec_ok), 32'd1);
    next_fetch(a); check("beq_next_z1", a, 32'd6);

    cyc(1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_req", 32'(bus.fetch_req), 32'd0);
      check("stall_pc", bus.pcinstruct, 32'd6);
      check("stall_word", fetch, 32'hE000_0006);
    end
    stall = 0;
    next_fetch(a); check("stall_resume", a, 32'd7);

    next_fetch(a); check("sbr_pc", a, 32'd8);
    cyc(1);
    stall = 1;
    cyc(2);
    check("sbr_frozen", bus.pcinstruct, 32'd8);
    stall = 0;
    next_fetch(a); check("sbr_target", a, 32'd14);

    next_fetch(a); check("wrap_255", a, 32'd255);
    next_fetch(a); check("wrap_0", a, 32'd0);

    ack_hold = 1;
    next_fetch(a); check("drop_pc", a, 32'd1);
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("drop_req_held", 32'(bus.fetch_req), 32'd1);
      check("drop_pc_stable", bus.pcinstruct, 32'd1);
    end
    ack_hold = 0;
    ivs = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (instr_valid) ivs++;
      if (!bus.fetch_req && !instr_valid) break;
    end
    check("drop_one_issue", 32'(ivs), 32'd1);
    cyc(2);
    check("drop_idle_req", 32'(bus.fetch_req), 32'd0);
    check("drop_idle_pc", bus.pcinstruct, 32'd2);

    enable = 1;
    ack_hold = 1;
    next_fetch(a); check("arst_pc_before", a, 32'd2);
    #4;
    reset = 0;
    #1;
    check("arst_req", 32'(bus.fetch_req), 32'd0);
    check("arst_pc", bus.pcinstruct, 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_fetch", fetch, 32'd0);
    cyc(2);
    ack_hold = 0;
    reset = 1;
    next_fetch(a); check("arst_restart", a, 32'd0);
    cyc(1);
    check("arst_fresh_word", fetch, 32'hE000_0000);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the program counter width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, the PC value loaded by reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  run enable; low holds the unit in IDLE.
REQ-006 SHALL have port stall  input  1  memorycontrol busy (LDR/STR); freezes issue.
REQ-007 SHALL have port fetch_ack  input  1  RAM has mem_rdata valid this cycle.
REQ-008 SHALL have port mem_rdata  input  32  instruction word from RAM.
REQ-009 SHALL have port n, z, c, v  input  1 each  ALU flags.
REQ-010 SHALL have port flag_we  input  1  capture ALU flags.
REQ-011 SHALL have port fetch_req  output  1  instruction read request to RAM.
REQ-012 SHALL have port pcinstruct  output  32  fetch address, zero-extended PC.
REQ-013 SHALL have port fetch  output  32  registered instruction word for the decoder, muxes, ALU and memorycontrol.
REQ-014 SHALL have port instr_valid  output  1  fetch is valid for issue this cycle.
REQ-015 SHALL have port exec_ok  output  1  condition field passed; qualifies register writes.
REQ-016 SHALL have port flags  output  4  latched {N,Z,C,V}.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, ISSUE, HOLD.
REQ-018 SHALL move IDLE->REQ when enable=1; otherwise SHALL remain in IDLE.
REQ-019 SHALL drive fetch_req=1 in REQ only.
REQ-020 SHALL, in REQ with fetch_ack=1, latch mem_rdata into fetch and move to ISSUE; without ack SHALL stay in REQ with a stable pcinstruct.
REQ-021 SHALL assert instr_valid for exactly one cycle in ISSUE.
REQ-022 SHALL, in ISSUE with stall=1, move to HOLD and keep fetch and PC unchanged until stall=0.
REQ-023 SHALL, in HOLD with stall=0, move to ISSUE without a new fetch.
REQ-024 SHALL, in ISSUE with stall=0, move to REQ; to IDLE if enable=0.
REQ-025 SHALL compute exec_ok combinationally from fetch[31:28] and the latched flags using ARM encodings: EQ..LE are 0000-1101, AL=1110 always passes, 1111 never passes.
REQ-026 SHALL, on ISSUE&!stall, update PC = PC+1 (mod 2^ADDR_W).
REQ-027 SHALL instead load PC + 1 + sign-extended fetch[ADDR_W-1:0] (mod 2^ADDR_W) when fetch[27:24]==4'b1010 (branch) and exec_ok=1.
REQ-028 SHALL leave the PC at the sequential value when a branch fails its condition.
REQ-029 SHALL wrap the PC from 2^ADDR_W-1 to 0 with no error indication.
REQ-030 SHALL update flags from {n,z,c,v} when flag_we=1 and instr_valid=1 and exec_ok=1; flag_we outside ISSUE SHALL be ignored.
REQ-031 SHALL, when enable falls during REQ, finish the pending fetch before returning to IDLE.
REQ-032 SHALL give stall priority over branch: a stalled branch SHALL redirect only on the ISSUE cycle in which stall=0.

Reset
REQ-033 SHALL, while reset=0, force the state to IDLE immediately, independent of clk.
REQ-034 SHALL, while reset=0, force PC=RESET_PC, fetch=0, flags=0, fetch_req=0, instr_valid=0.
REQ-035 SHALL abandon any pending REQ or HOLD on reset; no stale fetch SHALL issue afterwards.

Configuration
REQ-036 SHALL, with COND_EXEC_EN defined, behave per REQ-025.
REQ-037 SHALL, without COND_EXEC_EN, tie exec_ok=1 and treat all branches as taken; the flags register SHALL still update.

Structure
REQ-038 SHALL take the FSM state enum, OP_BRANCH=4'b1010 and the condition-code constants from shared package processor_pkg.
REQ-039 SHALL place the condition evaluation in one sub-module, cond_eval (inputs cond[3:0] and flags[3:0]; output pass).

Verification
REQ-040 SHALL cover: reset release, enable=1, RAM acks each REQ -> pcinstruct 0,1,2,3; instr_valid pulses once per instruction.
REQ-041 SHALL cover: fetch=32'hEA0000FE (AL branch, offset -2) at PC=5 -> next pcinstruct=4.
REQ-042 SHALL cover: flags Z=0, fetch=32'h0A000003 (BEQ) at PC=2 -> exec_ok=0, next PC=3; with Z=1 -> next PC=6.
REQ-043 SHALL cover: stall=1 for 3 cycles during ISSUE -> fetch and PC frozen, no fetch_req, then resume.
REQ-044 SHALL cover: PC=255 sequential issue -> pcinstruct=0.
REQ-045 SHALL cover: reset=0 mid-REQ, asynchronous to clk -> fetch_req=0 and PC=0 before the next clk edge.
